hmac_msg_packer: RTL and testbench
==================================

Name: hmac_msg_packer

Overview:
Upstream stage of the HMAC-SHA-256 engine. It accepts a message as a stream of 32-bit big-endian words and packs them into 512-bit blocks. It appends SHA-256 padding, sized for the (K xor ipad) block that is hashed ahead of the message, and presents each block with init/final flags and byte count on a valid/ready handshake. The HMAC engine consumes these flags as start/init/final_block and message_length.

Parameters:
PREFIX_BITS, 512, bits hashed ahead of the message (K xor ipad block); added into the SHA length field.
CNT_W, 32, width of the message byte counter; maximum message length is 2^CNT_W-1 bytes.

Ports:
clock      in   1    system clock
reset_n    in   1    async active-low reset
msg_valid  in   1    msg_data/msg_bytes/msg_last valid
msg_ready  out  1    packer accepts a word this cycle
msg_data   in   32   message word, first byte in [31:24]
msg_last   in   1    final word of the message
msg_bytes  in   3    valid bytes in the last word (0..4, left-justified); ignored when msg_last=0
blk_valid  out  1    blk_* outputs hold a block
blk_ready  in   1    downstream accepts a block (HMAC ready)
blk_data   out  512  block, word 0 in [511:480]
blk_init   out  1    first block of the message
blk_final  out  1    block contains the length field (last block)
blk_len    out  10   message bytes in this block, 0..64
overflow   out  1    sticky: byte counter wrapped; cleared by reset

Behaviour:
- Reset (async, reset_n=0): state=FILL, word index widx=0, byte count=0, first=1; blk_valid=0, blk_data=0, blk_init=0, blk_final=0, blk_len=0, overflow=0.
- msg_ready=1 only in FILL; blk_valid=1 only in EMIT. A word transfers when msg_valid&msg_ready; a block transfers when blk_valid&blk_ready.
- FILL: each accepted word is written to buffer slot widx. Non-last words count 4 bytes; widx increments.
  - Word 15 accepted with msg_last=0 -> EMIT (final=0, len=64); after transfer -> FILL, widx=0.
  - Last word with n=msg_bytes (values 5..7 treated as 4): bytes beyond n zeroed, byte 0x80 placed at offset u=widx*4+n, rest of block zeroed. n=0 allowed (empty tail or empty message).
  - If u<=55: the 64-bit length L = PREFIX_BITS + 8*total_bytes goes in bits [63:0] -> EMIT (final=1, len=u).
  - If 56<=u<=63: EMIT (final=0, len=u), then PAD.
  - If u=64: 0x80 does not fit; EMIT (final=0, len=64), then PAD with pad80=1.
- PAD: block = {pad80 ? 8'h80 : 8'h00, zeros, L[63:0]} -> EMIT (final=1, len=0).
- EMIT: blk_* registered and held stable while blk_valid=1 and blk_ready=0.
  - blk_init=first; first clears on any block transfer.
  - Transfer of a final block -> FILL, with widx, count and first reset for the next message.
- Latency: the block that completes in FILL at cycle t has blk_valid=1 at t+1. A PAD block is presented 1 cycle after the preceding transfer.
- Throughput: a block transferred at cycle t allows msg_ready=1 at t+1.
- Simultaneous events: no input word accepted while in EMIT/PAD (msg_ready=0). blk_ready while blk_valid=0 is ignored.
- Byte counter wraps mod 2^CNT_W; a wrap sets overflow. Length still uses the wrapped count.
- Reset mid-operation: the partial block is discarded and the next word starts a new message with init=1.

Test Plan:
- Empty message (msg_last=1, msg_bytes=0 at widx 0) -> one block, [511:504]=0x80, rest 0 except [63:0]=0x200; init=1, final=1, len=0.
- "abc" (msg_data=0x61626300, bytes=3, last) -> [511:480]=0x61626380, [63:0]=0x218, init=1, final=1, len=3.
- 56-byte message (13 full words + last word with 4 bytes) -> block 1: byte56=0x80, final=0, len=56, no length field; block 2: zeros plus L=0x3C0, init=0, final=1, len=0.
- 64-byte message (16 words, last on word 15) -> block 1 is data only (len=64, final=0); block 2: [511:504]=0x80, L=0x400, final=1.
- 100-byte message with blk_ready held low 5 cycles on each block -> blk_data stable and msg_ready=0 during the stall. Blocks: (init=1, len=64), then (len=36, final=1, L=0x520).
- Reset pulse after 7 words of a message -> outputs return to reset values; a following "abc" reproduces the "abc" result exactly.

Source files
------------

// File: rtl/hmac_msg_packer.sv
// Packs a 32-bit big-endian word stream into 512-bit SHA-256 blocks with HMAC-prefix-aware padding.
// Latency: a block completed by an accepted word is valid the next cycle; a pad block follows its predecessor's transfer by one cycle.
// Backpressure: words are only accepted while filling; a presented block is held stable until blk_ready.
module hmac_msg_packer #(
  parameter int PREFIX_BITS = 512,
  parameter int CNT_W       = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_init,
  output logic         blk_final,
  output logic [9:0]   blk_len,
  output logic         overflow
);

  // The pad-only block is loaded on the same edge the preceding block
  // transfers, so it never needs a cycle of its own outside EMIT.
  typedef enum logic {S_FILL, S_EMIT} state_t;

  state_t             r_state;
  logic [3:0]         r_widx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_first;
  logic               r_pad_pend;
  logic               r_pad80;
  logic [511:0]       r_blk_data;
  logic               r_init;
  logic               r_final;
  logic [9:0]         r_len;
  logic               r_ovf;

  logic [2:0]         w_n;
  logic [2:0]         w_add;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_carry;
  logic [6:0]         w_u;
  logic [31:0]        w_mask;
  logic [31:0]        w_word;
  logic [63:0]        w_len_new;
  logic [63:0]        w_len_cur;
  logic [511:0]       w_ins;
  logic [511:0]       w_tail;
  logic [511:0]       w_pad;

  assign w_n        = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
  assign w_add      = msg_last ? w_n : 3'd4;
  assign {w_carry, w_cnt_nxt} = {1'b0, r_cnt} + (CNT_W+1)'(w_add);
  assign w_u        = 7'({r_widx, 2'b00}) + 7'(w_n);
  assign w_word     = msg_data & w_mask;
  assign w_len_new  = 64'(PREFIX_BITS) + (64'(w_cnt_nxt) << 3);
  assign w_len_cur  = 64'(PREFIX_BITS) + (64'(r_cnt) << 3);
  assign w_pad      = {(r_pad80 ? 8'h80 : 8'h00), 440'd0, w_len_cur};

  // Keep only the first n bytes of the tail word; junk beyond them must not leak.
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    case (w_n)
      3'd0:    w_mask = 32'h0000_0000;
      3'd1:    w_mask = 32'hFF00_0000;
      3'd2:    w_mask = 32'hFFFF_0000;
      3'd3:    w_mask = 32'hFFFF_FF00;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Build the next buffer for a plain word (w_ins) and for a tail word with padding (w_tail).
  always_comb begin
    w_ins  = r_blk_data;
    w_tail = r_blk_data;
    for (int i = 0; i < 16; i++) begin
      if (4'(i) == r_widx) begin
        w_ins[511-32*i -: 32]  = msg_data;
        w_tail[511-32*i -: 32] = w_word;
      end else if (4'(i) > r_widx) begin
        w_tail[511-32*i -: 32] = 32'h0;
      end
    end
    for (int j = 0; j < 64; j++) begin
      if (w_u == 7'(j)) w_tail[511-8*j -: 8] = 8'h80;
    end
    if (w_u <= 7'd55) w_tail[63:0] = w_len_new;
  end

  // Fill/emit sequencing with registered block outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_FILL;
      r_widx     <= 4'd0;
      r_cnt      <= '0;
      r_first    <= 1'b1;
      r_pad_pend <= 1'b0;
      r_pad80    <= 1'b0;
      r_blk_data <= '0;
      r_init     <= 1'b0;
      r_final    <= 1'b0;
      r_len      <= 10'd0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (msg_valid) begin
            r_cnt <= w_cnt_nxt;
            if (w_carry) r_ovf <= 1'b1;
            if (msg_last) begin
              r_blk_data <= w_tail;
              r_init     <= r_first;
              r_len      <= 10'(w_u);
              r_widx     <= 4'd0;
              r_state    <= S_EMIT;
              if (w_u <= 7'd55) begin
                r_final    <= 1'b1;
                r_pad_pend <= 1'b0;
              end else begin
                r_final    <= 1'b0;
                r_pad_pend <= 1'b1;
                r_pad80    <= (w_u == 7'd64);
              end
            end else begin
              r_blk_data <= w_ins;
              if (r_widx == 4'd15) begin
                r_init     <= r_first;
                r_final    <= 1'b0;
                r_len      <= 10'd64;
                r_pad_pend <= 1'b0;
                r_widx     <= 4'd0;
                r_state    <= S_EMIT;
              end else begin
                r_widx <= r_widx + 4'd1;
              end
            end
          end
        end
        S_EMIT: begin
          if (blk_ready) begin
            r_first <= 1'b0;
            if (r_final) begin
              r_state <= S_FILL;
              r_widx  <= 4'd0;
              r_cnt   <= '0;
              r_first <= 1'b1;
            end else if (r_pad_pend) begin
              r_blk_data <= w_pad;
              r_init     <= 1'b0;
              r_final    <= 1'b1;
              r_len      <= 10'd0;
              r_pad_pend <= 1'b0;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign msg_ready = (r_state == S_FILL);
  assign blk_valid = (r_state == S_EMIT);
  assign blk_data  = r_blk_data;
  assign blk_init  = r_init;
  assign blk_final = r_final;
  assign blk_len   = r_len;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_hmac_msg_packer.sv
// Bench for hmac_msg_packer: table of messages checked against a standard SHA-256 padding model.
// Latency: checks fill-to-valid, transfer-to-pad and transfer-to-ready timing on each message.
// Backpressure: blk_ready is withheld per table entry and block stability is checked during the stall.
module tb_hmac_msg_packer;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         msg_valid;
  logic         msg_ready;
  logic [31:0]  msg_data;
  logic         msg_last;
  logic [2:0]   msg_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_init;
  logic         blk_final;
  logic [9:0]   blk_len;
  logic         overflow;

  always #5 clock = ~clock;

  hmac_msg_packer #(.PREFIX_BITS(512), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_init(blk_init), .blk_final(blk_final), .blk_len(blk_len),
    .overflow(overflow)
  );

  typedef struct {
    int nbytes;
    int stall;
    bit tail0;
    bit big_n;
    int exp_blocks;
  } vec_t;

  typedef struct {
    logic [511:0] data;
    bit           init;
    bit           fin;
    bit           pad;
    int           len;
  } blk_t;

  blk_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           blk_seen = 0;
  int           cur_stall = 0;
  int           stall_left = 0;
  bit           pad_chk = 0;
  bit           thr_chk = 0;
  logic [511:0] last_data = '0;
  vec_t         vecs[12];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int i);
    return 8'(32'h61 + i);
  endfunction

  // Standard SHA-256 padding of the message with a 512-bit prefix folded into the length.
  task automatic push_expected(input int nbytes, input bit tail0);
    logic [7:0]  pb [0:511];
    logic [63:0] lf;
    int          total;
    int          nblk;
    blk_t        b;
    total = ((nbytes + 9 + 63) / 64) * 64;
    for (int i = 0; i < 512; i++) pb[i] = 8'h00;
    for (int i = 0; i < nbytes; i++) pb[i] = msg_byte(i);
    pb[nbytes] = 8'h80;
    lf = 64'd512 + 64'((nbytes % 256) * 8);
    for (int k = 0; k < 8; k++) pb[total-1-k] = 8'(lf >> (8*k));
    nblk = total / 64;
    for (int k = 0; k < nblk; k++) begin
      for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = pb[64*k+j];
      b.init = (k == 0);
      b.fin  = (k == nblk - 1);
      b.len  = nbytes - 64*k;
      if (b.len < 0)  b.len = 0;
      if (b.len > 64) b.len = 64;
      b.pad  = (k > 0) && (b.len == 0) && !tail0;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
    int t;
    t = 0;
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = last;
    msg_bytes = nb;
    do begin
      @(negedge clock);
      t++;
    end while (!msg_ready && t < 500);
    if (!msg_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: msg_ready got 0 want 1");
    end
    @(posedge clock);
    #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_bytes = 3'd0;
    msg_data  = 32'h0;
  endtask

  task automatic run_msg(input vec_t v);
    int          words;
    int          n;
    int          target;
    int          t;
    logic [31:0] w;
    cur_stall = v.stall;
    target    = blk_seen + v.exp_blocks;
    push_expected(v.nbytes, v.tail0);
    if (v.nbytes == 0) begin
      send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    end else begin
      words = (v.nbytes + 3) / 4;
      for (int wi = 0; wi < words; wi++) begin
        for (int k = 0; k < 4; k++)
          w[31-8*k -: 8] = (4*wi + k < v.nbytes) ? msg_byte(4*wi + k) : 8'hEE;
        if (wi < words - 1) begin
          send_word(w, 1'b0, 3'd0);
        end else begin
          n = v.nbytes - 4*wi;
          if (v.tail0 && n == 4) begin
            send_word(w, 1'b0, 3'd0);
            send_word(32'hCAFE_F00D, 1'b1, 3'd0);
          end else begin
            send_word(w, 1'b1, (v.big_n && n == 4) ? 3'd7 : 3'(n));
          end
        end
      end
    end
    @(negedge clock);
    chk_i("fill_latency", int'(blk_valid), 1);
    t = 0;
    while (blk_seen < target && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk_i("block_count", blk_seen, target);
  endtask

  task automatic chk_reset();
    chk_i("rst_blk_valid", int'(blk_valid), 0);
    chk("rst_blk_data", blk_data, 512'd0);
    chk_i("rst_blk_init", int'(blk_init), 0);
    chk_i("rst_blk_final", int'(blk_final), 0);
    chk_i("rst_blk_len", int'(blk_len), 0);
    chk_i("rst_overflow", int'(overflow), 0);
    chk_i("rst_msg_ready", int'(msg_ready), 1);
  endtask

  // Scoreboard monitor: drives blk_ready (with stalls) and checks each transferred block.
  initial begin
    blk_t e;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        pad_chk    = 0;
        thr_chk    = 0;
        blk_ready  = 1'b1;
        stall_left = cur_stall;
      end else begin
        if (pad_chk) begin
          chk_i("pad_latency", int'(blk_valid), 1);
          pad_chk = 0;
        end
        if (thr_chk) begin
          chk_i("msg_ready_after_final", int'(msg_ready), 1);
          thr_chk = 0;
        end
        if (blk_valid) begin
          chk_i("msg_ready_in_emit", int'(msg_ready), 0);
          if (stall_left > 0) begin
            stall_left--;
            blk_ready = 1'b0;
            if (exp_q.size() > 0) chk("stall_hold", blk_data, exp_q[0].data);
          end else begin
            blk_ready = 1'b1;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_block: got len %0d want no block", blk_len);
            end else begin
              e = exp_q.pop_front();
              chk("blk_data", blk_data, e.data);
              chk_i("blk_init", int'(blk_init), int'(e.init));
              chk_i("blk_final", int'(blk_final), int'(e.fin));
              chk_i("blk_len", int'(blk_len), e.len);
              last_data = blk_data;
              blk_seen++;
              if (!e.fin && exp_q.size() > 0 && exp_q[0].pad) pad_chk = 1;
              if (e.fin) thr_chk = 1;
            end
            stall_left = cur_stall;
          end
        end else begin
          blk_ready  = 1'b1;
          stall_left = cur_stall;
        end
      end
    end
  end

  initial begin
    vec_t abc;
    vecs[0]  = '{0,   0, 1'b0, 1'b0, 1};
    vecs[1]  = '{3,   0, 1'b0, 1'b0, 1};
    vecs[2]  = '{55,  0, 1'b0, 1'b0, 1};
    vecs[3]  = '{56,  0, 1'b0, 1'b1, 2};
    vecs[4]  = '{63,  1, 1'b0, 1'b0, 2};
    vecs[5]  = '{64,  0, 1'b0, 1'b0, 2};
    vecs[6]  = '{64,  0, 1'b1, 1'b0, 2};
    vecs[7]  = '{100, 5, 1'b0, 1'b0, 2};
    vecs[8]  = '{8,   1, 1'b1, 1'b0, 1};
    vecs[9]  = '{120, 0, 1'b0, 1'b1, 3};
    vecs[10] = '{128, 2, 1'b0, 1'b0, 3};
    vecs[11] = '{260, 0, 1'b0, 1'b0, 5};
    abc      = '{3,   0, 1'b0, 1'b0, 1};

    reset_n   = 1'b0;
    blk_ready = 1'b1;
    msg_valid = 1'b0;
    msg_data  = 32'h0;
    msg_last  = 1'b0;
    msg_bytes = 3'd0;
    #1;
    chk_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_msg(vecs[i]);
    chk_i("overflow_clear", int'(overflow), 0);

    // Byte counter wraps at 256 here: the length field uses the wrapped count.
    run_msg(vecs[11]);
    chk_i("overflow_set", int'(overflow), 1);

    // Abort a message mid-block, then check a fresh message starts cleanly.
    for (int i = 0; i < 7; i++) send_word(32'h0102_0300 + 32'(i), 1'b0, 3'd0);
    reset_n = 1'b0;
    #1;
    chk_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_msg(abc);
    chk("abc_word0", 512'(last_data[511:480]), 512'(32'h6162_6380));
    chk("abc_length", 512'(last_data[63:0]), 512'(64'h218));
    chk_i("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
